// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, key schedule and FSM encodings
// used by the iterative encryption engine.
package aes_pkg;

  typedef logic [1:0] fsm_t;
  localparam fsm_t S_IDLE  = 2'd0;
  localparam fsm_t S_ROUND = 2'd1;
  localparam fsm_t S_DONE  = 2'd2;

  // Entry b lives at bits [(255-b)*8 +: 8], so the index is simply {~b, 3'b000}.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON_T = 80'h01020408102040801b36;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int i);
    return RCON_T[80 - 8*i +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Full FIPS-197 schedule; key is MSB-aligned in 256 bits, w[i] is word i.
  function automatic logic [59:0][31:0] expand_key(input logic [255:0] key, input int nk);
    logic [59:0][31:0] w;
    logic [31:0]       t;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i < nk) w[i] = key[255 - 32*i -: 32];
    for (int i = 4; i < 60; i++) begin
      if (i >= nk && i < 4 * (nr_of(nk) + 1)) begin
        t = w[i-1];
        if (i % nk == 0)                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
        else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [127:0] sr, mc;

  // Byte k = row (k%4), column (k/4); row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127 - 8*(4*c + r) -: 8] = sbox(st[127 - 8*(4*((c + r) % 4) + r) -: 8]);
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
  end

  assign nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock, valid/ready on both sides,
// one block in flight at a time.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [32*NK-1:0]  in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  localparam int NR = nr_of(NK);
  localparam int KW = 32 * NK;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_encrypt_iter: NK must be 4, 6 or 8");
  end

  fsm_t            fsm;
  logic [127:0]    st_q;
  logic [KW-1:0]   key_q;
  logic [3:0]      rnd_q;

  logic [255:0]      key_full;
  logic [59:0][31:0] ks;
  logic [5:0]        base;
  logic [127:0]      rk, nxt;
  logic              last;

  // Schedule is recomputed from the captured key; only words 4r..4r+3 are used.
  always_comb begin
    key_full = '0;
    key_full[255 -: KW] = key_q;
    ks   = expand_key(key_full, NK);
    base = {rnd_q, 2'b00};
    rk   = {ks[base], ks[base + 6'd1], ks[base + 6'd2], ks[base + 6'd3]};
  end

  assign last = (rnd_q == 4'(NR));

  aes_round u_round (
    .st   (st_q),
    .rk   (rk),
    .last (last),
    .nxt  (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= S_IDLE;
      st_q  <= '0;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (in_valid) begin
          st_q  <= in_data ^ in_key[KW-1 -: 128];
          key_q <= in_key;
          rnd_q <= 4'd1;
          fsm   <= S_ROUND;
        end
        S_ROUND: begin
          st_q <= nxt;
          if (last) fsm   <= S_DONE;
          else      rnd_q <= rnd_q + 4'd1;
        end
        S_DONE:  if (out_ready) fsm <= S_IDLE;
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);
  assign busy      = (fsm != S_IDLE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: NK=4/6/8 instances share stimulus; a byte-level AES model
// predicts ciphertexts and a per-cycle compare checks handshake and data.
module tb_aes_encrypt_iter;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ZCT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [255:0] key = '0;
  logic [2:0]   ir, ov, bz;
  logic [127:0] od [3];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int K = 4 + 2*g;
    aes_encrypt_iter #(.NK(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_key    (key[255 -: 32*K]),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .busy      (bz[g])
    );
  end

  // ---------------- reference AES (byte arrays, computed S-box) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbx(input logic [7:0] x);
    logic [7:0] inv, p;
    int e;
    inv = 8'h01; p = x; e = 254;
    while (e > 0) begin
      if (e % 2 == 1) inv = gmul(inv, p);
      p = gmul(p, p);
      e = e / 2;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbx(t[31:24]), sbx(t[23:16]), sbx(t[15:8]), sbx(t[7:0])};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [255:0] k, input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = sbx(s[4*((c+j)%4) + j]);
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) begin
          if (r == nr) s[4*c+j] = t[4*c+j];
          else s[4*c+j] = gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03) ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
          s[4*c+j] = s[4*c+j] ^ w[4*r+c][31 - 8*j -: 8];
        end
    end
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- transaction model: idle / busy for NR edges / done ----------------
  int           m_st  [3];
  int           m_cnt [3];
  logic [127:0] m_ct  [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_st[i] <= 0; m_cnt[i] <= 0; m_ct[i] <= '0;
      end else begin
        case (m_st[i])
          0: if (in_valid) begin
            m_ct[i]  <= model_enc(in_data, key, 4 + 2*i);
            m_cnt[i] <= 10 + 2*i;
            m_st[i]  <= 1;
          end
          1: begin
            m_cnt[i] <= m_cnt[i] - 1;
            if (m_cnt[i] == 1) m_st[i] <= 2;
          end
          default: if (out_ready) m_st[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[nk%0d]", 4+2*i),  128'(ir[i]), 128'(m_st[i] == 0));
        chk($sformatf("out_valid[nk%0d]", 4+2*i), 128'(ov[i]), 128'(m_st[i] == 2));
        chk($sformatf("busy[nk%0d]", 4+2*i),      128'(bz[i]), 128'(m_st[i] != 0));
        if (m_st[i] == 2) chk($sformatf("out_data[nk%0d]", 4+2*i), od[i], m_ct[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         lat [3];
    int         nacc [3];
    int         nov, nacc4;
    logic [2:0] pre;
    logic [127:0] ct [3];
    ct = '{CT4, CT6, CT8};

    fork cmp_loop(); join_none

    // the reference itself against published vectors
    chk("model_aes128", model_enc(PT, KEY, 4), CT4);
    chk("model_aes192", model_enc(PT, KEY, 6), CT6);
    chk("model_aes256", model_enc(PT, KEY, 8), CT8);
    chk("model_zero",   model_enc('0, '0, 4), ZCT);

    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready",  128'(ir[i]), 128'd1);
      chk("reset_out_valid", 128'(ov[i]), 128'd0);
      chk("reset_busy",      128'(bz[i]), 128'd0);
      chk("reset_out_data",  od[i], '0);
    end
    #20 rst_n = 1'b1;

    // known-answer with latency, then 20+ cycles of backpressure
    in_data = PT; key = KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = '{-1, -1, -1};
    for (int c = 1; c <= 30; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] < 0) lat[i] = c;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency_nk%0d", 4+2*i), 128'(lat[i]), 128'(10 + 2*i));
      chk($sformatf("kat_nk%0d", 4+2*i), od[i], ct[i]);
    end
    chk("held_in_ready", 128'(ir[0]), 128'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_in_ready", 128'(ir), 128'b111);

    // inputs churn while rounds run
    in_data = PT; key = KEY; in_valid = 1'b1;
    step();
    nacc4 = 0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pre = ir;
      step();
      if (in_valid && pre[0]) nacc4++;
    end
    in_valid = 1'b0;
    repeat (10) step();
    chk("churn_no_accept", 128'(nacc4), 128'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("churn_kat_nk%0d", 4+2*i), od[i], ct[i]);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset in the middle of round processing
    in_data = PT; key = KEY; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_in_ready",  128'(ir), 128'b111);
    chk("midreset_out_valid", 128'(ov), 128'b000);
    chk("midreset_busy",      128'(bz), 128'b000);
    chk("midreset_out_data",  od[0], '0);
    #1 rst_n = 1'b1;
    in_data = '0; key = '0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = '{-1, -1, -1};
    for (int c = 1; c <= 16; c++) begin
      step();
      if (ov[0] && lat[0] < 0) lat[0] = c;
    end
    chk("post_reset_latency", 128'(lat[0]), 128'd10);
    chk("post_reset_kat",     od[0], ZCT);
    out_ready = 1'b1;
    step();

    // back-to-back with out_ready held high
    in_data = '0; key = '0; in_valid = 1'b1;
    nacc = '{0, 0, 0};
    nov = 0;
    for (int e = 0; e < 34; e++) begin
      pre = ir;
      step();
      for (int i = 0; i < 3; i++) if (pre[i]) nacc[i]++;
      if (ov[0]) nov++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_accepts_nk%0d", 4+2*i), 128'(nacc[i]), 128'd3);
    chk("b2b_out_valid_cycles", 128'(nov), 128'd2);
    repeat (20) step();
    chk("drain_in_ready", 128'(ir), 128'b111);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
